// File: rtl/mvm_requant_fifo_pkg.sv
// Shared types and defaults for the MVM output requantiser / WDMA FIFO stage.
// Widths here are the defaults used by the top, the bus interface and the bench.
package mvm_requant_fifo_pkg;

  localparam int TOUT_P   = 16;
  localparam int DW_P     = 8;
  localparam int ACC_W_P  = 24;
  localparam int FIFO_D_P = 16;
  localparam int CNT_W_P  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Half-LSB rounding bias for a right shift; zero shift needs no bias.
  function automatic logic [31:0] round_bias(input logic [4:0] shift);
    logic [31:0] b;
    b = '0;
    if (shift != 5'd0) b = 32'd1 << (shift - 5'd1);
    return b;
  endfunction

endpackage

// File: rtl/mvm_requant_fifo_if.sv
// Streaming bus of the requant stage: MVM accumulator input and WDMA valid/ready output.
interface mvm_requant_fifo_if
  import mvm_requant_fifo_pkg::*;
#(
  parameter int TOUT  = TOUT_P,
  parameter int DW    = DW_P,
  parameter int ACC_W = ACC_W_P
) ();

  logic [TOUT*ACC_W-1:0] acc_in;
  logic                  acc_vld;
  logic [TOUT*DW-1:0]    dat_out_pd;
  logic                  dat_out_vld;
  logic                  dat_out_rdy;

  modport master (
    output acc_in, acc_vld, dat_out_rdy,
    input  dat_out_pd, dat_out_vld
  );

  modport slave (
    input  acc_in, acc_vld, dat_out_rdy,
    output dat_out_pd, dat_out_vld
  );

endinterface

// File: rtl/mvm_requant_fifo_sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output and flush.
// Occupancy includes the word shown on dout; a push into the slot that becomes the head bypasses memory.
module mvm_requant_fifo_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty && !flush;
  // When full, a push only lands if the head leaves in the same cycle.
  assign push_ok = push && !flush && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    vld_d  = (wr_ptr_d != rd_ptr_d);
    dout_d = dout_q;
    if (vld_d) begin
      if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) dout_d = din;
      else                                                   dout_d = mem[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      dout_q   <= dout_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;

endmodule

// File: rtl/mvm_requant_fifo.sv
// MVM output stage: per-lane round/shift/ReLU/saturate, buffered into a FIFO toward WDMA,
// with a per-layer vector count that pulses done once every accepted vector is delivered or dropped.
module mvm_requant_fifo
  import mvm_requant_fifo_pkg::*;
#(
  parameter int TOUT   = TOUT_P,
  parameter int DW     = DW_P,
  parameter int ACC_W  = ACC_W_P,
  parameter int FIFO_D = FIFO_D_P,
  parameter int CNT_W  = CNT_W_P
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       cfg_shift,
  input  logic             cfg_relu,
  input  logic [CNT_W-1:0] cfg_words,
  input  logic             start,
  mvm_requant_fifo_if.slave bus,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int LW = ACC_W + 1;
  localparam logic signed [LW-1:0] SAT_HI = LW'((1 << (DW - 1)) - 1);
  localparam logic signed [LW-1:0] SAT_LO = ~SAT_HI;

  state_e           state_q, state_d;
  logic [4:0]       shift_q, shift_d;
  logic             relu_q, relu_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, cnt_inc;
  logic             overflow_q, overflow_d;
  logic             zdone_q, zdone_d;
  logic             p1_vld_q, p1_vld_d;
  logic             p2_vld_q, p2_vld_d;
  logic [TOUT*LW-1:0] p1_data_q, p1_data_d, s1_vec;
  logic [TOUT*DW-1:0] p2_data_q, p2_data_d, sat_vec;
  logic [LW-1:0]    bias;
  logic             accept, drained, fifo_pop, fifo_full, fifo_empty;

  assign bias     = LW'(round_bias(shift_q));
  assign accept   = (state_q == ST_RUN) && bus.acc_vld && !start;
  assign fifo_pop = bus.dat_out_vld && bus.dat_out_rdy;
  assign drained  = !p1_vld_q && !p2_vld_q && fifo_empty;
  assign cnt_inc  = in_cnt_q + CNT_W'(1);

  // Stage 1 rounds and shifts in ACC_W+1 bits; stage 2 applies ReLU and saturation.
  for (genvar gi = 0; gi < TOUT; gi++) begin : g_lane
    logic signed [LW-1:0] ext, sum, p1_lane;
    assign ext     = {bus.acc_in[gi*ACC_W + ACC_W - 1], bus.acc_in[gi*ACC_W +: ACC_W]};
    assign sum     = ext + $signed(bias);
    assign s1_vec[gi*LW +: LW] = sum >>> shift_q;
    assign p1_lane = p1_data_q[gi*LW +: LW];
    assign sat_vec[gi*DW +: DW] = (relu_q && p1_lane[LW-1]) ? '0 :
                                  (p1_lane > SAT_HI)        ? SAT_HI[DW-1:0] :
                                  (p1_lane < SAT_LO)        ? SAT_LO[DW-1:0] :
                                                              p1_lane[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    words_d  = words_q;
    in_cnt_d = in_cnt_q;
    zdone_d  = 1'b0;
    if (start) begin
      shift_d  = cfg_shift;
      relu_d   = cfg_relu;
      words_d  = cfg_words;
      in_cnt_d = '0;
      zdone_d  = (cfg_words == '0);
      state_d  = (cfg_words == '0) ? ST_IDLE : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            in_cnt_d = cnt_inc;
            if (cnt_inc == words_q) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drained) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = zdone_q || ((state_q == ST_DRAIN) && drained && !start);
    overflow = overflow_q;
  end

  always_comb begin
    p1_vld_d   = accept;
    p1_data_d  = accept ? s1_vec : p1_data_q;
    p2_vld_d   = p1_vld_q && !start;
    p2_data_d  = p1_vld_q ? sat_vec : p2_data_q;
    // A P2 word finding the FIFO full with no pop this cycle is lost.
    overflow_d = start ? 1'b0 : (overflow_q || (p2_vld_q && fifo_full && !fifo_pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      relu_q     <= 1'b0;
      words_q    <= '0;
      in_cnt_q   <= '0;
      overflow_q <= 1'b0;
      zdone_q    <= 1'b0;
      p1_vld_q   <= 1'b0;
      p1_data_q  <= '0;
      p2_vld_q   <= 1'b0;
      p2_data_q  <= '0;
    end else begin
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      words_q    <= words_d;
      in_cnt_q   <= in_cnt_d;
      overflow_q <= overflow_d;
      zdone_q    <= zdone_d;
      p1_vld_q   <= p1_vld_d;
      p1_data_q  <= p1_data_d;
      p2_vld_q   <= p2_vld_d;
      p2_data_q  <= p2_data_d;
    end
  end

  mvm_requant_fifo_sync_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (TOUT*DW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (start),
    .push     (p2_vld_q),
    .pop      (fifo_pop),
    .din      (p2_data_q),
    .dout     (bus.dat_out_pd),
    .dout_vld (bus.dat_out_vld),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
